// File: rtl/dmem_arbiter_if.sv
// One requester's connection to the dmem arbiter: request fields in, grant and response out.
interface dmem_arbiter_if #(
  parameter int XLEN = 64
);
  logic            req;
  logic            we;
  logic            lock;
  logic [2:0]      op;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic            err;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, lock, op, addr, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, lock, op, addr, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port dmem, with bounded
// lock, misaligned-access rejection and a one-cycle registered load response.
module dmem_arbiter #(
  parameter int XLEN     = 64,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   m0,
  dmem_arbiter_if.slave   m1,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      mem_op,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);
  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [2:0]      MEM_INV  = 3'd7;

  // Codes outside the defined set are checked as byte accesses.
  function automatic logic misaligned(input logic [2:0] op, input logic [2:0] lsb);
    logic [1:0] sz_log2;
    sz_log2 = (op == MEM_INV) ? 2'd0 : op[1:0];
    case (sz_log2)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lsb[0];
      2'd2:    misaligned = |lsb[1:0];
      default: misaligned = |lsb;
    endcase
  endfunction

  logic            prio;
  logic            owner;
  logic            owner_vld;
  logic [HW-1:0]   hold_cnt;
  logic            any_req;
  logic            lock_active;
  logic            sel;
  logic            sel_we;
  logic            sel_lock;
  logic            sel_mis;
  logic [2:0]      sel_op;
  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] sel_wdata;
  logic [1:0]      rsp_vld_p1;
  logic [1:0]      rsp_err_p1;
  logic [XLEN-1:0] rdata0_p1;
  logic [XLEN-1:0] rdata1_p1;

  // p0: combinational grant and dmem drive
  always_comb begin
    any_req     = m0.req | m1.req;
    lock_active = owner_vld & (owner ? m1.req : m0.req);
    if (m0.req && m1.req)
      sel = (lock_active && (hold_cnt < HOLD_MAX)) ? owner : prio;
    else
      sel = m1.req;
  end

  assign sel_we    = sel ? m1.we    : m0.we;
  assign sel_lock  = sel ? m1.lock  : m0.lock;
  assign sel_op    = sel ? m1.op    : m0.op;
  assign sel_addr  = sel ? m1.addr  : m0.addr;
  assign sel_wdata = sel ? m1.wdata : m0.wdata;
  assign sel_mis   = misaligned(sel_op, sel_addr[2:0]);

  assign m0.gnt    = any_req & ~sel;
  assign m1.gnt    = any_req & sel;
  assign mem_read  = any_req & ~sel_mis & ~sel_we;
  assign mem_write = any_req & ~sel_mis & sel_we;
  assign mem_op    = any_req ? sel_op    : '0;
  assign mem_addr  = any_req ? sel_addr  : '0;
  assign mem_wdata = any_req ? sel_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      owner     <= 1'b0;
      owner_vld <= 1'b0;
      hold_cnt  <= '0;
    end else if (any_req) begin
      prio      <= ~sel;
      owner     <= sel;
      owner_vld <= sel_lock;
      if (owner_vld && (owner == sel))
        hold_cnt <= (hold_cnt < HOLD_MAX) ? hold_cnt + 1'b1 : HOLD_MAX;
      else
        hold_cnt <= HW'(1);
    end
  end

  // p1: registered response, one cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1 <= '0;
      rsp_err_p1 <= '0;
      rdata0_p1  <= '0;
      rdata1_p1  <= '0;
    end else begin
      rsp_vld_p1 <= '0;
      rsp_err_p1 <= '0;
      if (any_req) begin
        if (sel_mis) begin
          rsp_err_p1[sel] <= 1'b1;
        end else if (!sel_we) begin
          rsp_vld_p1[sel] <= 1'b1;
          if (sel) rdata1_p1 <= mem_rdata;
          else     rdata0_p1 <= mem_rdata;
        end
      end
    end
  end

  assign m0.rvalid = rsp_vld_p1[0];
  assign m0.err    = rsp_err_p1[0];
  assign m0.rdata  = rdata0_p1;
  assign m1.rvalid = rsp_vld_p1[1];
  assign m1.err    = rsp_err_p1[1];
  assign m1.rdata  = rdata1_p1;
endmodule
